// File: rtl/semaphore_timer_datapath_pkg.sv
// Shared types and helpers for the semaphore datapath and its control FSM.
package semaphore_timer_datapath_pkg;

   typedef enum logic [1:0] {RED, GREEN, YELLOW} estado_t;

   // The product can exceed 32 bits at realistic clock rates, so widen before dividing
   function automatic int lim_cycles(input int hz, input int tenths);
      return int'((longint'(hz) * longint'(tenths)) / 64'sd10);
   endfunction

   function automatic int cnt_width(input int lim);
      return (lim > 1) ? $clog2(lim) : 1;
   endfunction

endpackage

// File: rtl/semaphore_timer_datapath_if.sv
// Strobe/flag bundle between the semaphore FSM (master) and its timer datapath (slave).
interface semaphore_timer_datapath_if;

   logic load_Reg5s;
   logic clear_Reg5s;
   logic load_Reg7s;
   logic clear_Reg7s;
   logic load_Reg05s;
   logic clear_Reg05s;
   logic ped_btn;
   logic fim_5s;
   logic fim_7s;
   logic fim_05s;
   logic pedestrian;

   modport master (
      output load_Reg5s, clear_Reg5s, load_Reg7s, clear_Reg7s,
             load_Reg05s, clear_Reg05s, ped_btn,
      input  fim_5s, fim_7s, fim_05s, pedestrian
   );

   modport slave (
      input  load_Reg5s, clear_Reg5s, load_Reg7s, clear_Reg7s,
             load_Reg05s, clear_Reg05s, ped_btn,
      output fim_5s, fim_7s, fim_05s, pedestrian
   );

endinterface

// File: rtl/semaphore_timer_datapath_phase_timer.sv
// Phase timer: wrapping counter of LIM cycles with a combinational terminal flag.
module semaphore_timer_datapath_phase_timer
   import semaphore_timer_datapath_pkg::*;
#(
   parameter int LIM = 50
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic clear,
   output logic fim
);

   localparam int W = cnt_width(LIM);
   localparam logic [W-1:0] LAST = W'(LIM - 1);

   logic [W-1:0] r_cnt;

   // Load outranks clear: yellow asserts both and the timer must keep running
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (load) begin
         r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
      end else if (clear) begin
         r_cnt <= '0;
      end
   end

   assign fim = load && (r_cnt == LAST);

endmodule

// File: rtl/semaphore_timer_datapath.sv
// Semaphore datapath: three phase timers plus pedestrian button conditioning.
// Optional feature macro: SEMAPHORE_PED_LATCH_EN (hold the request until yellow serves it).
module semaphore_timer_datapath
   import semaphore_timer_datapath_pkg::*;
#(
   parameter int CLK_HZ          = 50_000_000,
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic                      clk,
   input  logic                      rst,
   semaphore_timer_datapath_if.slave bus
);

   localparam int T5_LIM  = lim_cycles(CLK_HZ, 50);
   localparam int T7_LIM  = lim_cycles(CLK_HZ, 70);
   localparam int T05_LIM = lim_cycles(CLK_HZ, 5);

   localparam int DEB_W = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

   logic w_fim5s;
   logic w_fim7s;
   logic w_fim05s;
   logic w_risePulse;

   logic             r_sync1;
   logic             r_pedS;
   logic [DEB_W-1:0] r_debCnt;
   logic             r_debLvl;
   logic             r_debLvlQ;

   semaphore_timer_datapath_phase_timer #(.LIM(T5_LIM)) u_timer5s (
      .clk   (clk),
      .rst   (rst),
      .load  (bus.load_Reg5s),
      .clear (bus.clear_Reg5s),
      .fim   (w_fim5s)
   );

   semaphore_timer_datapath_phase_timer #(.LIM(T7_LIM)) u_timer7s (
      .clk   (clk),
      .rst   (rst),
      .load  (bus.load_Reg7s),
      .clear (bus.clear_Reg7s),
      .fim   (w_fim7s)
   );

   semaphore_timer_datapath_phase_timer #(.LIM(T05_LIM)) u_timer05s (
      .clk   (clk),
      .rst   (rst),
      .load  (bus.load_Reg05s),
      .clear (bus.clear_Reg05s),
      .fim   (w_fim05s)
   );

   assign bus.fim_5s  = w_fim5s;
   assign bus.fim_7s  = w_fim7s;
   assign bus.fim_05s = w_fim05s;

   // The accepted level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1   <= 1'b0;
         r_pedS    <= 1'b0;
         r_debCnt  <= '0;
         r_debLvl  <= 1'b0;
         r_debLvlQ <= 1'b0;
      end else begin
         r_sync1   <= bus.ped_btn;
         r_pedS    <= r_sync1;
         r_debLvlQ <= r_debLvl;
         if (r_pedS != r_debLvl) begin
            if (r_debCnt == DEB_LAST) begin
               r_debLvl <= r_pedS;
               r_debCnt <= '0;
            end else begin
               r_debCnt <= r_debCnt + 1'b1;
            end
         end else begin
            r_debCnt <= '0;
         end
      end
   end

   assign w_risePulse = r_debLvl & ~r_debLvlQ;

`ifdef SEMAPHORE_PED_LATCH_EN
   logic r_pedReq;

   // Entering yellow means the request was served; that clear beats a simultaneous new press
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pedReq <= 1'b0;
      end else if (bus.load_Reg05s) begin
         r_pedReq <= 1'b0;
      end else if (w_risePulse) begin
         r_pedReq <= 1'b1;
      end
   end

   assign bus.pedestrian = r_pedReq;
`else
   logic r_pedPulse;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pedPulse <= 1'b0;
      end else begin
         r_pedPulse <= w_risePulse;
      end
   end

   assign bus.pedestrian = r_pedPulse;
`endif

endmodule

// File: tb/tb_semaphore_timer_datapath.sv
// Scoreboard bench for semaphore_timer_datapath (CLK_HZ=10, DEBOUNCE_CYCLES=4).
module tb_semaphore_timer_datapath;

`ifdef SEMAPHORE_PED_LATCH_EN
   localparam bit LATCH = 1'b1;
`else
   localparam bit LATCH = 1'b0;
`endif

   localparam logic [5:0] NONE = 6'b000000;
   localparam logic [5:0] L5   = 6'b100000;
   localparam logic [5:0] L7   = 6'b001000;
   localparam logic [5:0] C7   = 6'b000100;
   localparam logic [5:0] L05  = 6'b000010;
   localparam logic [5:0] C05  = 6'b000001;

   typedef struct {
      logic [3:0] exp;
      string      name;
   } expT;

   logic clock;
   logic reset;
   expT  sbQ[$];
   int   checks;
   int   failures;

   semaphore_timer_datapath_if bus ();

   semaphore_timer_datapath #(
      .CLK_HZ          (10),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk (clock),
      .rst (reset),
      .bus (bus)
   );

   // Free-running clock, period 10
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Drive one cycle of inputs on the falling edge and queue what the outputs must show
   task automatic applyStimulus(input logic r, input logic [5:0] ctl, input logic btn,
                                input logic [3:0] exp, input string name, input bit doCheck);
      @(negedge clock);
      reset            = r;
      bus.load_Reg5s   = ctl[5];
      bus.clear_Reg5s  = ctl[4];
      bus.load_Reg7s   = ctl[3];
      bus.clear_Reg7s  = ctl[2];
      bus.load_Reg05s  = ctl[1];
      bus.clear_Reg05s = ctl[0];
      bus.ped_btn      = btn;
      if (doCheck) sbQ.push_back('{exp, name});
   endtask

   task automatic doReset();
      applyStimulus(1'b1, NONE, 1'b0, 4'b0000, "pre_reset", 1'b0);
      applyStimulus(1'b1, NONE, 1'b0, 4'b0000, "reset", 1'b1);
   endtask

   task automatic checkOutput(input expT e);
      logic [3:0] actual;
      actual = {bus.fim_5s, bus.fim_7s, bus.fim_05s, bus.pedestrian};
      checks++;
      if (actual !== e.exp) begin
         failures++;
         $display("[TB] FAIL %s at %0t: {fim_5s,fim_7s,fim_05s,pedestrian} got %b expected %b",
                  e.name, $time, actual, e.exp);
      end
   endtask

   // Monitor: compare mid-cycle, well away from the rising edge
   initial begin
      forever begin
         @(negedge clock);
         #2;
         if (sbQ.size() > 0) checkOutput(sbQ.pop_front());
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      bus.load_Reg5s   = 1'b0;
      bus.clear_Reg5s  = 1'b0;
      bus.load_Reg7s   = 1'b0;
      bus.clear_Reg7s  = 1'b0;
      bus.load_Reg05s  = 1'b0;
      bus.clear_Reg05s = 1'b0;
      bus.ped_btn      = 1'b0;

      // Red timer: terminal on enabled cycle 50, then wraps for another 50
      doReset();
      for (int i = 0; i < 100; i++)
         applyStimulus(1'b0, L5, 1'b0, {(i % 50 == 49), 3'b000}, "t1_red_fim", 1'b1);

      // Yellow with clear held too: load wins, flag every 5 cycles
      doReset();
      for (int i = 0; i < 12; i++)
         applyStimulus(1'b0, L05 | C05, 1'b0, {2'b00, (i % 5 == 4), 1'b0}, "t2_yellow_fim", 1'b1);

      // Green: partial count, clear, then a full 70 cycles
      doReset();
      for (int i = 0; i < 30; i++)
         applyStimulus(1'b0, L7, 1'b0, 4'b0000, "t3_green_partial", 1'b1);
      applyStimulus(1'b0, C7, 1'b0, 4'b0000, "t3_green_clear", 1'b1);
      for (int i = 0; i < 75; i++)
         applyStimulus(1'b0, L7, 1'b0, {1'b0, (i == 69), 2'b00}, "t3_green_fim", 1'b1);

      // Reset mid-count with load held leaves no residue
      doReset();
      for (int i = 0; i < 30; i++)
         applyStimulus(1'b0, L5, 1'b0, 4'b0000, "t5_precount", 1'b1);
      applyStimulus(1'b1, L5, 1'b0, 4'b0000, "t5_midreset", 1'b1);
      for (int i = 0; i < 60; i++)
         applyStimulus(1'b0, L5, 1'b0, {(i == 49), 3'b000}, "t5_after_reset", 1'b1);

      // Pedestrian: short glitch rejected, held press yields one pulse, re-arm after release
      doReset();
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b0, NONE, 1'b0, 4'b0000, "t4_idle", 1'b1);
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b0, NONE, 1'b1, 4'b0000, "t4_glitch", 1'b1);
      for (int i = 0; i < 12; i++)
         applyStimulus(1'b0, NONE, 1'b0, 4'b0000, "t4_glitch_after", 1'b1);
      for (int i = 0; i < 20; i++)
         applyStimulus(1'b0, NONE, 1'b1, {3'b000, LATCH ? (i >= 7) : (i == 7)}, "t4_press", 1'b1);
      for (int i = 0; i < 15; i++)
         applyStimulus(1'b0, NONE, 1'b0, {3'b000, LATCH}, "t4_release", 1'b1);
      for (int i = 0; i < 10; i++)
         applyStimulus(1'b0, NONE, 1'b1, {3'b000, LATCH ? 1'b1 : (i == 7)}, "t4_repress", 1'b1);
      for (int i = 0; i < 15; i++)
         applyStimulus(1'b0, NONE, 1'b0, {3'b000, LATCH}, "t4_release2", 1'b1);

      // Latched request survives red and is cleared by the first yellow cycle
      if (LATCH) begin
         doReset();
         for (int i = 0; i < 20; i++)
            applyStimulus(1'b0, L5, 1'b1, {3'b000, (i >= 7)}, "t6_press_in_red", 1'b1);
         for (int i = 0; i < 5; i++)
            applyStimulus(1'b0, L5, 1'b0, 4'b0001, "t6_held_in_red", 1'b1);
         applyStimulus(1'b0, L05, 1'b0, 4'b0001, "t6_yellow_entry", 1'b1);
         for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, NONE, 1'b0, 4'b0000, "t6_served", 1'b1);
      end

      repeat (3) @(negedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
